waveform_stepper: RTL and testbench
===================================

// Module: waveform_stepper
// PURPOSE
//  Consumes the divided step clock from the clock divider stage and advances a phase index once per
//  step_clk rising edge. Each step yields one SAMPLE_W-bit sample of the selected waveform, offered
//  downstream (DAC interface) on a valid/ready handshake. Same clk domain as the divider.
// PARAMETERS
//  PHASE_W   8    phase index width; 2^PHASE_W samples per waveform period
//  SAMPLE_W  12   sample width; must satisfy SAMPLE_W >= PHASE_W
// PORTS
//  clk           in   1         system clock (same clock as the divider)
//  rst           in   1         asynchronous, active-high reset
//  step_clk      in   1         divided clock from the divider; one step per rising edge
//  enable        in   1         1 = run; 0 = phase held at 0, steps ignored
//  wave_sel      in   2         0 square, 1 sawtooth, 2 triangle, 3 sine/mid-scale (see CONFIGURATION)
//  sample_data   out  SAMPLE_W  current sample; stable while sample_valid & ~sample_ready
//  sample_valid  out  1         sample pending
//  sample_ready  in   1         downstream accepts when valid & ready at posedge
//  phase         out  PHASE_W   current phase index
//  overrun_cnt   out  8         count of steps dropped by backpressure; saturates at 255
//  ovr_clr       in   1         synchronous clear of overrun_cnt
// BEHAVIOUR
//  - Reset: phase=0, sample_data=0, sample_valid=0, overrun_cnt=0, step_prev=0. Takes effect immediately, even mid-handshake.
//  - step_prev registers step_clk; tick = step_clk & ~step_prev (rising edge only, 1-cycle pulse).
//  - Output state is the valid flag: EMPTY (valid=0) / FULL (valid=1).
//  - On a posedge with tick & enable: phase <= phase+1, wrapping 2^PHASE_W-1 -> 0.
//    If EMPTY, or FULL and transferring this edge: sample_data <= wave(phase before increment); valid <= 1.
//    Latency: sample is visible the cycle after tick. The first sample after reset or enable is phase 0.
//  - FULL & ready & no tick -> EMPTY. FULL & ready & tick -> stays FULL, new data loaded (no bubble).
//  - FULL & ~ready & tick -> overrun: phase still advances; sample_data is not overwritten;
//    overrun_cnt += 1, saturating at 255.
//  - ovr_clr has priority over a simultaneous overrun increment (result 0).
//  - enable=0: phase <= 0 every cycle. Ticks are ignored and are not counted as overruns.
//    A pending sample remains until accepted.
//  - wave_sel is sampled only when a sample is generated; a change applies to the next sample.
//  - Waveforms, with P=PHASE_W, S=SAMPLE_W, ph=phase:
//    square   = ph[P-1] ? 0 : 2^S-1
//    sawtooth = ph << (S-P)
//    triangle = (ph[P-1] ? ~ph[P-2:0] : ph[P-2:0]) << (S-P+1)
// CONFIGURATION
//  - Macro WAVEFORM_SINE_LUT_EN defined: wave_sel=3 selects a sine sample,
//    offset binary, 0 .. 2^S-1, centred on 2^(S-1). Read from a quarter-wave table of
//    2^(P-2) entries, unfolded by ph[P-1:P-2] symmetry. Combinational read; latency unchanged.
//  - Macro undefined: no table is built; wave_sel=3 yields constant mid-scale 2^(S-1).
// STRUCTURE
//  - Shared package signal_gen_pkg: WAVE_SQUARE/WAVE_SAW/WAVE_TRI/WAVE_SINE select encodings,
//    width 2; OVR_CNT_W=8.
//  - Sub-module wave_sine_rom (quarter-wave table plus symmetry unfold), instantiated only under
//    WAVEFORM_SINE_LUT_EN. Everything else is in this module.
// TESTING  (P=8, S=12)
//  1. Saw, ready=1, step_clk period 8 clk -> samples 0x000,0x010,0x020,...; phase 255 -> 0xFF0,
//     then 0x000 (wrap).
//  2. Square -> phases 0..127 give 0xFFF, 128..255 give 0x000.
//     Triangle -> phase 0=0x000, 1=0x020, 127=0xFE0, 128=0xFE0, 255=0x000.
//  3. Backpressure: ready=0, 3 ticks from EMPTY -> sample_data holds the phase-0 sample,
//     overrun_cnt=2, phase=3. Then ready=1 -> one transfer, valid=0 next cycle.
//  4. Tick on the same edge as a transfer -> valid stays 1, new data next cycle.
//     Overrun with ovr_clr asserted -> overrun_cnt=0.
//  5. Assert rst while valid=1 mid-period -> all outputs 0 without waiting for clk.
//     After release, first sample is phase 0.
//  6. wave_sel=3: macro off -> 0x800. Macro on -> phase 0 = 0x800, 64 ~ 0xFFF, 192 ~ 0x000.
//     enable=0 -> phase=0, no new samples.

Source files
------------

// File: rtl/signal_gen_pkg.sv
// Shared definitions for the signal generator blocks: waveform select
// encodings, output-buffer states and the overrun counter width.
package signal_gen_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_sel_e;

  // The output buffer holds at most one sample; its valid flag is the state.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  localparam int OVR_CNT_W = 8;

endpackage

// File: rtl/waveform_stepper_if.sv
// Sample stream towards the DAC: data plus valid/ready handshake.
interface waveform_stepper_if #(
  parameter int SAMPLE_W = 12
);
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/wave_sine_rom.sv
// Quarter-wave sine table with symmetry unfold, offset-binary output centred
// on mid-scale. Table contents are elaborated from an integer Bhaskara
// approximation, so no external memory image is needed. Pure combinational.
module wave_sine_rom #(
  parameter int PHASE_W  = 8,
  parameter int SAMPLE_W = 12
) (
  input  logic [PHASE_W-1:0]  phase,
  output logic [SAMPLE_W-1:0] sample
);

  localparam int IDX_W   = PHASE_W - 2;
  localparam int QUARTER = 1 << IDX_W;
  localparam logic [SAMPLE_W-2:0] PEAK = {(SAMPLE_W-1){1'b1}};
  localparam logic [SAMPLE_W-1:0] MID  = {1'b1, {(SAMPLE_W-1){1'b0}}};

  // amplitude * sin(pi*idx/(2*QUARTER)) using 16u(1-u)/(5-4u(1-u)), u = idx/(2*QUARTER)
  function automatic logic [SAMPLE_W-2:0] quarter_val(input int idx);
    longint a;
    longint n;
    longint num;
    longint den;
    longint amp;
    a   = longint'(idx);
    n   = longint'(QUARTER) * 64'sd2;
    num = 64'sd16 * a * (n - a);
    den = 64'sd5 * n * n - 64'sd4 * a * (n - a);
    amp = (64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1;
    return (SAMPLE_W-1)'((amp * num) / den);
  endfunction

  logic [SAMPLE_W-2:0] quarter_tab [QUARTER];

  for (genvar g = 0; g < QUARTER; g++) begin : g_tab
    assign quarter_tab[g] = quarter_val(g);
  end

  logic [1:0]          quad_s;
  logic [IDX_W-1:0]    idx_s;
  logic [IDX_W-1:0]    mirror_s;
  logic [SAMPLE_W-2:0] mag_s;

  // Fold the phase into the first quadrant, look up magnitude, apply sign.
  always_comb begin
    quad_s   = phase[PHASE_W-1:PHASE_W-2];
    idx_s    = phase[IDX_W-1:0];
    mirror_s = {IDX_W{1'b0}} - idx_s;
    mag_s    = quarter_tab[idx_s];
    if (quad_s[0]) begin
      // Descending quadrants read the table backwards; index 0 maps to the peak.
      if (idx_s == {IDX_W{1'b0}}) begin
        mag_s = PEAK;
      end else begin
        mag_s = quarter_tab[mirror_s];
      end
    end else begin
      mag_s = quarter_tab[idx_s];
    end
    if (quad_s[1]) begin
      sample = MID - SAMPLE_W'(mag_s);
    end else begin
      sample = MID + SAMPLE_W'(mag_s);
    end
  end

endmodule

// File: rtl/waveform_stepper.sv
// Waveform stepper: advances a phase index on each rising edge of the divided
// step clock and offers one waveform sample per step on a valid/ready stream.
// Steps arriving while a sample is still pending are dropped and counted.
// Optional feature macro WAVEFORM_SINE_LUT_EN: when defined, wave_sel=3 reads
// a sine table; otherwise wave_sel=3 gives constant mid-scale.
module waveform_stepper
  import signal_gen_pkg::*;
#(
  parameter int PHASE_W  = 8,
  parameter int SAMPLE_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_clk,
  input  logic                 enable,
  input  logic [1:0]           wave_sel,
  input  logic                 ovr_clr,
  output logic [PHASE_W-1:0]   phase,
  output logic [OVR_CNT_W-1:0] overrun_cnt,
  waveform_stepper_if.master   dac
);

  localparam logic [SAMPLE_W-1:0]  MID      = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0]  ALL_ONES = {SAMPLE_W{1'b1}};
  localparam logic [SAMPLE_W-1:0]  ZERO     = {SAMPLE_W{1'b0}};
  localparam logic [OVR_CNT_W-1:0] OVR_MAX  = {OVR_CNT_W{1'b1}};

  out_state_e            state_r;
  out_state_e            state_s;
  logic                  step_prev_r;
  logic                  tick_s;
  logic                  step_s;
  logic                  load_s;
  logic                  overrun_s;
  logic [PHASE_W-1:0]    phase_r;
  logic [SAMPLE_W-1:0]   sample_r;
  logic [OVR_CNT_W-1:0]  overrun_r;
  logic [SAMPLE_W-1:0]   wave_s;
  logic [SAMPLE_W-1:0]   sine_s;
  logic [PHASE_W-2:0]    tri_s;
  wave_sel_e             sel_s;

  assign tick_s = step_clk & ~step_prev_r;
  assign step_s = tick_s & enable;
  assign sel_s  = wave_sel_e'(wave_sel);

`ifdef WAVEFORM_SINE_LUT_EN
  wave_sine_rom #(
    .PHASE_W  (PHASE_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_sine_rom (
    .phase  (phase_r),
    .sample (sine_s)
  );
`else
  assign sine_s = MID;
`endif

  // Waveform value for the current (pre-increment) phase.
  always_comb begin
    wave_s = MID;
    if (phase_r[PHASE_W-1]) begin
      tri_s = ~phase_r[PHASE_W-2:0];
    end else begin
      tri_s = phase_r[PHASE_W-2:0];
    end
    case (sel_s)
      WAVE_SQUARE: begin
        if (phase_r[PHASE_W-1]) begin
          wave_s = ZERO;
        end else begin
          wave_s = ALL_ONES;
        end
      end
      WAVE_SAW:  wave_s = SAMPLE_W'(phase_r) << (SAMPLE_W - PHASE_W);
      WAVE_TRI:  wave_s = SAMPLE_W'(tri_s) << (SAMPLE_W - PHASE_W + 1);
      WAVE_SINE: wave_s = sine_s;
      default:   wave_s = MID;
    endcase
  end

  // Output buffer next state: decide load, drop (overrun) or drain.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    overrun_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (step_s) begin
          state_s = ST_FULL;
          load_s  = 1'b1;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (step_s) begin
          if (dac.sample_ready) begin
            load_s = 1'b1;
          end else begin
            overrun_s = 1'b1;
          end
          state_s = ST_FULL;
        end else if (dac.sample_ready) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // Output buffer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Delay step_clk one cycle for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_prev_r <= 1'b0;
    end else begin
      step_prev_r <= step_clk;
    end
  end

  // Phase index: held at zero while disabled, advances once per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= {PHASE_W{1'b0}};
    end else if (!enable) begin
      phase_r <= {PHASE_W{1'b0}};
    end else if (tick_s) begin
      phase_r <= phase_r + PHASE_W'(1);
    end else begin
      phase_r <= phase_r;
    end
  end

  // Sample register: only rewritten when a new sample is accepted into the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_r <= ZERO;
    end else if (load_s) begin
      sample_r <= wave_s;
    end else begin
      sample_r <= sample_r;
    end
  end

  // Dropped-step counter, saturating; clear wins over a same-cycle drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_r <= {OVR_CNT_W{1'b0}};
    end else if (ovr_clr) begin
      overrun_r <= {OVR_CNT_W{1'b0}};
    end else if (overrun_s && (overrun_r != OVR_MAX)) begin
      overrun_r <= overrun_r + OVR_CNT_W'(1);
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign dac.sample_data  = sample_r;
  assign dac.sample_valid = (state_r == ST_FULL);
  assign phase            = phase_r;
  assign overrun_cnt      = overrun_r;

endmodule

// File: tb/tb_waveform_stepper.sv
// Directed bench for waveform_stepper (PHASE_W=8, SAMPLE_W=12).
module tb_waveform_stepper;
  import signal_gen_pkg::*;

  localparam int P = 8;
  localparam int S = 12;

`ifdef WAVEFORM_SINE_LUT_EN
  localparam logic [31:0] SINE_64  = 32'h0000_0FFF;
  localparam logic [31:0] SINE_192 = 32'h0000_0001;
`else
  localparam logic [31:0] SINE_64  = 32'h0000_0800;
  localparam logic [31:0] SINE_192 = 32'h0000_0800;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         step_clk;
  logic         enable;
  logic [1:0]   wave_sel;
  logic         ovr_clr;
  logic [P-1:0] phase;
  logic [7:0]   overrun_cnt;

  int checks = 0;
  int errors = 0;

  waveform_stepper_if #(.SAMPLE_W(S)) dac_if ();

  waveform_stepper #(
    .PHASE_W  (P),
    .SAMPLE_W (S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .step_clk    (step_clk),
    .enable      (enable),
    .wave_sel    (wave_sel),
    .ovr_clr     (ovr_clr),
    .phase       (phase),
    .overrun_cnt (overrun_cnt),
    .dac         (dac_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One step_clk pulse: high for one clk edge, then low; returns at the
  // negedge right after the edge on which the step was taken.
  task automatic tick();
    @(negedge clk) step_clk = 1'b1;
    @(negedge clk) step_clk = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    step_clk = 1'b0;
    enable   = 1'b0;
    wave_sel = 2'd1;
    ovr_clr  = 1'b0;
    dac_if.sample_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(dac_if.sample_valid), 32'd0);
    check("rst_data", 32'(dac_if.sample_data), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_ovr", 32'(overrun_cnt), 32'd0);
    rst = 1'b0;

    // 1. sawtooth, step period 8 clk, through the wrap
    enable = 1'b1;
    dac_if.sample_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= 256; i++) begin
      tick();
      check("saw", 32'(dac_if.sample_data), 32'((i % 256) << 4));
      check("saw_valid", 32'(dac_if.sample_valid), 32'd1);
      repeat (6) @(negedge clk);
    end
    check("saw_phase_wrap", 32'(phase), 32'd1);

    // 2. square and triangle over a full period each
    enable = 1'b0;
    @(negedge clk);
    check("dis_phase", 32'(phase), 32'd0);
    enable = 1'b1;
    wave_sel = 2'd0;
    for (int i = 0; i < 256; i++) begin
      tick();
      check("square", 32'(dac_if.sample_data), (i < 128) ? 32'h0FFF : 32'h0000);
    end
    wave_sel = 2'd2;
    for (int i = 0; i < 256; i++) begin
      tick();
      check("triangle", 32'(dac_if.sample_data), (i < 128) ? 32'(i << 5) : 32'((255 - i) << 5));
    end

    // 3. backpressure from EMPTY: three steps, two dropped
    @(negedge clk);
    dac_if.sample_ready = 1'b0;
    check("drain_valid", 32'(dac_if.sample_valid), 32'd0);
    wave_sel = 2'd1;
    repeat (3) tick();
    check("bp_data", 32'(dac_if.sample_data), 32'h000);
    check("bp_valid", 32'(dac_if.sample_valid), 32'd1);
    check("bp_ovr", 32'(overrun_cnt), 32'd2);
    check("bp_phase", 32'(phase), 32'd3);
    dac_if.sample_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(dac_if.sample_valid), 32'd0);

    // 4. step coinciding with a transfer: no bubble
    dac_if.sample_ready = 1'b0;
    tick();
    check("load_data", 32'(dac_if.sample_data), 32'h030);
    @(negedge clk);
    dac_if.sample_ready = 1'b1;
    step_clk = 1'b1;
    @(negedge clk);
    step_clk = 1'b0;
    dac_if.sample_ready = 1'b0;
    check("xfer_tick_valid", 32'(dac_if.sample_valid), 32'd1);
    check("xfer_tick_data", 32'(dac_if.sample_data), 32'h040);
    check("xfer_tick_phase", 32'(phase), 32'd5);
    check("xfer_tick_ovr", 32'(overrun_cnt), 32'd2);
    // saturation of the overrun counter
    repeat (256) tick();
    check("ovr_sat", 32'(overrun_cnt), 32'd255);
    check("ovr_sat_data", 32'(dac_if.sample_data), 32'h040);
    check("ovr_sat_phase", 32'(phase), 32'd5);

    // 5. asynchronous reset mid-handshake
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(dac_if.sample_valid), 32'd0);
    check("arst_data", 32'(dac_if.sample_data), 32'd0);
    check("arst_phase", 32'(phase), 32'd0);
    check("arst_ovr", 32'(overrun_cnt), 32'd0);
    @(negedge clk) rst = 1'b0;
    wave_sel = 2'd0;
    tick();
    check("post_rst_data", 32'(dac_if.sample_data), 32'h0FFF);
    check("post_rst_phase", 32'(phase), 32'd1);
    // overrun then clear on the same edge as another overrun
    tick();
    check("ovr_one", 32'(overrun_cnt), 32'd1);
    @(negedge clk);
    step_clk = 1'b1;
    ovr_clr = 1'b1;
    @(negedge clk);
    step_clk = 1'b0;
    ovr_clr = 1'b0;
    check("ovr_clr_prio", 32'(overrun_cnt), 32'd0);
    check("ovr_clr_phase", 32'(phase), 32'd3);

    // 6. enable=0 holds phase, ignores steps, keeps the pending sample
    enable = 1'b0;
    repeat (3) tick();
    check("dis_hold_phase", 32'(phase), 32'd0);
    check("dis_hold_valid", 32'(dac_if.sample_valid), 32'd1);
    check("dis_hold_data", 32'(dac_if.sample_data), 32'h0FFF);
    check("dis_no_ovr", 32'(overrun_cnt), 32'd0);
    dac_if.sample_ready = 1'b1;
    @(negedge clk);
    check("dis_drain", 32'(dac_if.sample_valid), 32'd0);
    tick();
    check("dis_no_sample", 32'(dac_if.sample_valid), 32'd0);

    // wave_sel=3 at phases 0, 64, 192
    enable = 1'b1;
    wave_sel = 2'd3;
    tick();
    check("sine_ph0", 32'(dac_if.sample_data), 32'h0800);
    repeat (63) tick();
    tick();
    check("sine_ph64", 32'(dac_if.sample_data), SINE_64);
    repeat (127) tick();
    tick();
    check("sine_ph192", 32'(dac_if.sample_data), SINE_192);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
